// File: rtl/tempsense_sar_ctrl_pkg.sv
// Shared definitions for the tempsense SAR controller: FSM encodings and default timing.
package tempsense_sar_ctrl_pkg;

  typedef logic [2:0] sar_state_t;

  localparam sar_state_t ST_IDLE   = 3'd0;
  localparam sar_state_t ST_WARMUP = 3'd1;
  localparam sar_state_t ST_SETTLE = 3'd2;
  localparam sar_state_t ST_DECIDE = 3'd3;
  localparam sar_state_t ST_DONE   = 3'd4;

  localparam int DEF_BITWIDTH      = 6;
  localparam int DEF_WARMUP_CYCLES = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tempsense_sar_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module tempsense_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/tempsense_sar_ctrl.sv
// Successive-approximation controller for the temperature-sensor DAC: binary-searches the DAC
// code that matches the sensor voltage and reports it with a one-cycle valid pulse.
module tempsense_sar_ctrl
  import tempsense_sar_ctrl_pkg::*;
#(
  parameter int BITWIDTH      = DEF_BITWIDTH,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                comp_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_enable_o,
  output logic                busy_o,
  output logic [BITWIDTH-1:0] result_o,
  output logic                result_valid_o
);

  localparam int K_W   = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam int CNT_W = $clog2(max_int(WARMUP_CYCLES, SETTLE_CYCLES) + 1);

  localparam logic [K_W-1:0]      K_TOP       = K_W'(BITWIDTH - 1);
  localparam logic [CNT_W-1:0]    WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BITWIDTH-1:0] MID_CODE    = BITWIDTH'(1) << (BITWIDTH - 1);

  sar_state_t          state;
  logic [K_W-1:0]      k;
  logic [CNT_W-1:0]    cnt;
  logic                comp_s;
  logic [BITWIDTH-1:0] trial;

  tempsense_sync2 u_comp_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (comp_i),
    .sync_out (comp_s)
  );

  assign busy_o = (state != ST_IDLE);

  // The DAC code register doubles as the SAR register, so the DAC only ever sees registered codes.
  always_comb begin
    trial = dac_data_o;
    if (comp_s) trial[k] = 1'b0;
    if (k != '0) trial[k - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      k              <= '0;
      cnt            <= '0;
      dac_data_o     <= '0;
      dac_enable_o   <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            dac_data_o   <= MID_CODE;
            k            <= K_TOP;
            cnt          <= '0;
            dac_enable_o <= 1'b1;
            state        <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (cnt == WARMUP_LAST) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_DECIDE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DECIDE: begin
          dac_data_o <= trial;
          if (k != '0) begin
            k     <= k - 1'b1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_o       <= dac_data_o;
          result_valid_o <= 1'b1;
          dac_enable_o   <= 1'b0;
          dac_data_o     <= '0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Self-checking bench for tempsense_sar_ctrl: comparator model, vector table and scoreboard.
module tb_tempsense_sar_ctrl;

  localparam int LAT   = 8 + 6 * (4 + 1) + 1;
  localparam int LAT8  = 1 + 8 * (2 + 1) + 1;
  localparam int HOLD  = 60;
  localparam int NVEC  = 7;

  typedef struct {
    int exp;
    int start_edge;
  } sb_t;

  typedef struct {
    int x;
    int exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       start8 = 1'b0;
  logic [5:0] x = '0;
  logic [7:0] x8 = '0;

  logic [5:0] dac_data, result;
  logic       dac_enable, busy, result_valid, comp;
  logic [7:0] dac_data8, result8;
  logic       dac_enable8, busy8, result_valid8, comp8;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  sb_t  sb_q[$];
  sb_t  sb8_q[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign comp  = dac_enable  && (dac_data  > x);
  assign comp8 = dac_enable8 && (dac_data8 > x8);

  tempsense_sar_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start),
    .comp_i         (comp),
    .dac_data_o     (dac_data),
    .dac_enable_o   (dac_enable),
    .busy_o         (busy),
    .result_o       (result),
    .result_valid_o (result_valid)
  );

  tempsense_sar_ctrl #(
    .BITWIDTH      (8),
    .WARMUP_CYCLES (1),
    .SETTLE_CYCLES (2)
  ) dut8 (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start8),
    .comp_i         (comp8),
    .dac_data_o     (dac_data8),
    .dac_enable_o   (dac_enable8),
    .busy_o         (busy8),
    .result_o       (result8),
    .result_valid_o (result_valid8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== 32'(req)) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input int xv, input int ev, output int s0);
    @(negedge clk);
    x     = 6'(xv);
    start = 1'b1;
    s0    = cyc + 1;
    sb_q.push_back('{exp: ev, start_edge: s0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(sb_q.size()), 0);
    @(negedge clk);
    checkOutput("valid_width", 32'(result_valid), 0);
  endtask

  // Scoreboards: each valid pulse must match the oldest outstanding request in value and latency.
  always @(negedge clk) begin
    sb_t e;
    if (reset_n && result_valid) begin
      checkOutput("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("result", 32'(result), e.exp);
        checkOutput("latency", 32'(cyc - e.start_edge), LAT);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (reset_n && result_valid8) begin
      checkOutput("sb8_nonempty", 32'(sb8_q.size() != 0), 1);
      if (sb8_q.size() != 0) begin
        e = sb8_q.pop_front();
        checkOutput("result8", 32'(result8), e.exp);
        checkOutput("latency8", 32'(cyc - e.start_edge), LAT8);
      end
    end
  end

  initial begin
    int s0;
    int cnt_low;

    vecs[0] = '{x: 37, exp: 37};
    vecs[1] = '{x: 31, exp: 31};
    vecs[2] = '{x: 32, exp: 32};
    vecs[3] = '{x: 0,  exp: 0};
    vecs[4] = '{x: 63, exp: 63};
    vecs[5] = '{x: 21, exp: 21};
    vecs[6] = '{x: 50, exp: 50};

    repeat (2) @(negedge clk);
    checkOutput("rst_dac_enable", 32'(dac_enable), 0);
    checkOutput("rst_dac_data", 32'(dac_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_valid", 32'(result_valid), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].x, vecs[i].exp, s0);
      checkOutput("busy_during", 32'(busy), 1);
      checkOutput("enable_during", 32'(dac_enable), 1);
      waitDrain(LAT + 10);
      checkOutput("idle_dac_data", 32'(dac_data), 0);
    end

    // Held start: a new conversion begins every LAT+1 edges while start stays high.
    @(negedge clk);
    x     = 6'd10;
    start = 1'b1;
    s0    = cyc + 1;
    for (int n = 0; s0 + n * (LAT + 1) < s0 + HOLD; n++)
      sb_q.push_back('{exp: 10, start_edge: s0 + n * (LAT + 1)});
    cnt_low = 0;
    while (cyc < s0 + 2 * (LAT + 1) - 2) begin
      @(negedge clk);
      if (cyc == s0 + HOLD - 1) start = 1'b0;
      if (!busy) cnt_low++;
    end
    checkOutput("b2b_idle_gap", 32'(cnt_low), 1);
    waitDrain(LAT + 10);

    // A start presented only during the DONE cycle must be dropped.
    repeat (5) @(negedge clk);
    applyStimulus(44, 44, s0);
    while (cyc < s0 + LAT - 1) @(negedge clk);
    checkOutput("done_busy", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt_low = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (busy) cnt_low++;
    end
    checkOutput("no_queued_start", 32'(cnt_low), 0);
    checkOutput("queue_after_done", 32'(sb_q.size()), 0);

    // Reset mid-conversion aborts at once and clears the held result.
    applyStimulus(27, 27, s0);
    while (cyc < s0 + 20) @(negedge clk);
    checkOutput("pre_abort_enable", 32'(dac_enable), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_enable", 32'(dac_enable), 0);
    checkOutput("abort_dac_data", 32'(dac_data), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_result", 32'(result), 0);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(45, 45, s0);
    waitDrain(LAT + 10);

    // Alternate geometry: 8-bit code, minimal warmup and settle.
    foreach (vecs[i]) if (i < 2) begin
      @(negedge clk);
      x8     = (i == 0) ? 8'd200 : 8'd255;
      start8 = 1'b1;
      sb8_q.push_back('{exp: (i == 0) ? 200 : 255, start_edge: cyc + 1});
      @(negedge clk);
      start8 = 1'b0;
      for (int j = 0; j < LAT8 + 10 && sb8_q.size() != 0; j++) @(negedge clk);
      checkOutput("drain8", 32'(sb8_q.size()), 0);
      checkOutput("idle8_dac_data", 32'(dac_data8), 0);
      checkOutput("idle8_busy", 32'(busy8), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
